// File: rtl/lfsr_rand_gen.sv
// Fibonacci LFSR random source with enable-gated free run, run-time seeding
// and a bounded draw port using rejection sampling with a deterministic fallback.
module lfsr_rand_gen #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
   parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
   parameter int unsigned      OUT_W     = 8,
   parameter int unsigned      MAX_TRIES = 4
) (
   input  logic             clk0,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] rand_out,
   input  logic             req_valid,
   input  logic [OUT_W-1:0] req_lim,
   output logic             req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic             rsp_fallback
);

   localparam int unsigned      ATT_W    = $clog2(MAX_TRIES) + 1;
   localparam logic [ATT_W-1:0] LAST_TRY = ATT_W'(MAX_TRIES - 1);
   localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);
   localparam logic [OUT_W-1:0] LIM_ONE  = OUT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] s_r;
   logic [WIDTH-1:0] s_nxt_s;
   logic [OUT_W-1:0] lim_r;
   logic [ATT_W-1:0] attempts_r;
   logic [OUT_W-1:0] rsp_data_r;
   logic             rsp_fallback_r;
   logic             req_ready_r;
   logic             rsp_valid_r;
   logic             req_ready_nxt_s;
   logic             rsp_valid_nxt_s;
   logic             step_s;
   logic             req_acc_s;
   logic [OUT_W-1:0] cand_s;
   logic [OUT_W-1:0] diff_s;
   logic [OUT_W-1:0] fb_data_s;
   logic             accept_s;
   logic             last_try_s;

   function automatic logic parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Candidate evaluation for the current draw attempt
   always_comb begin
      cand_s     = s_r[OUT_W-1:0];
      accept_s   = (cand_s < lim_r);
      diff_s     = cand_s - lim_r;
      last_try_s = (attempts_r == LAST_TRY);
      req_acc_s  = (state_r == IDLE) && req_valid;
      if (diff_s < lim_r) begin
         fb_data_s = diff_s;
      end else begin
         fb_data_s = lim_r - LIM_ONE;
      end
   end

   // LFSR next state: seed load beats stepping; DRAW forces a step
   always_comb begin
      case (state_r)
         DRAW:      step_s = 1'b1;
         IDLE,
         HOLD:      step_s = en;
         default:   step_s = 1'b0;
      endcase
      if (seed_load) begin
         s_nxt_s = (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
      end else if (step_s) begin
         s_nxt_s = {s_r[WIDTH-2:0], parity(s_r & TAPS)};
      end else begin
         s_nxt_s = s_r;
      end
   end

   // Draw FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_acc_s) begin
               state_nxt_s = (req_lim == {OUT_W{1'b0}}) ? HOLD : DRAW;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DRAW: begin
            if (accept_s || last_try_s) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = DRAW;
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake flags decoded from the next state so they come out of flops
   always_comb begin
      case (state_nxt_s)
         IDLE:    begin req_ready_nxt_s = 1'b1; rsp_valid_nxt_s = 1'b0; end
         HOLD:    begin req_ready_nxt_s = 1'b0; rsp_valid_nxt_s = 1'b1; end
         default: begin req_ready_nxt_s = 1'b0; rsp_valid_nxt_s = 1'b0; end
      endcase
   end

   // FSM state and handshake flag registers
   always_ff @(posedge clk0) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         req_ready_r <= req_ready_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
      end
   end

   // LFSR, captured limit, attempt counter and response registers
   always_ff @(posedge clk0) begin
      if (!rst_n) begin
         s_r            <= SEED;
         lim_r          <= {OUT_W{1'b0}};
         attempts_r     <= {ATT_W{1'b0}};
         rsp_data_r     <= {OUT_W{1'b0}};
         rsp_fallback_r <= 1'b0;
      end else begin
         s_r <= s_nxt_s;
         case (state_r)
            IDLE: begin
               if (req_acc_s) begin
                  lim_r      <= req_lim;
                  attempts_r <= {ATT_W{1'b0}};
                  if (req_lim == {OUT_W{1'b0}}) begin
                     rsp_data_r     <= {OUT_W{1'b0}};
                     rsp_fallback_r <= 1'b0;
                  end
               end
            end
            DRAW: begin
               if (accept_s) begin
                  rsp_data_r     <= cand_s;
                  rsp_fallback_r <= 1'b0;
               end else if (last_try_s) begin
                  rsp_data_r     <= fb_data_s;
                  rsp_fallback_r <= 1'b1;
               end else begin
                  attempts_r <= attempts_r + ATT_ONE;
               end
            end
            default: begin
               lim_r <= lim_r;
            end
         endcase
      end
   end

   assign rand_out     = s_r;
   assign req_ready    = req_ready_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_data     = rsp_data_r;
   assign rsp_fallback = rsp_fallback_r;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen at WIDTH=4, TAPS=4'b1100, SEED=4'hF,
// OUT_W=4, MAX_TRIES=4 with hand-computed expected sequences.
module tb_lfsr_rand_gen;

   logic       clk0;
   logic       rst_n;
   logic       en;
   logic       seed_load;
   logic [3:0] seed_in;
   logic [3:0] rand_out;
   logic       req_valid;
   logic [3:0] req_lim;
   logic       req_ready;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_fallback;

   int n_chk;
   int n_pass;

   logic [3:0] fr_exp [0:15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

   lfsr_rand_gen #(
      .WIDTH     (4),
      .TAPS      (4'b1100),
      .SEED      (4'hF),
      .OUT_W     (4),
      .MAX_TRIES (4)
   ) dut (
      .clk0         (clk0),
      .rst_n        (rst_n),
      .en           (en),
      .seed_load    (seed_load),
      .seed_in      (seed_in),
      .rand_out     (rand_out),
      .req_valid    (req_valid),
      .req_lim      (req_lim),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_fallback (rsp_fallback)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic request(input logic [3:0] lim);
      req_valid = 1'b1;
      req_lim   = lim;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      seed_load = 1'b0;
      seed_in   = 4'h0;
      req_valid = 1'b0;
      req_lim   = 4'h0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_rand", 32'(rand_out), 32'hF);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_fb", 32'(rsp_fallback), 32'd0);

      // free run through the full period
      rst_n = 1'b1;
      en    = 1'b1;
      chk("free0", 32'(rand_out), 32'(fr_exp[0]));
      for (int i = 1; i < 16; i++) begin
         tick();
         chk($sformatf("free%0d", i), 32'(rand_out), 32'(fr_exp[i]));
      end
      en = 1'b0;

      // accept path, lim=9: candidates F,E,C,8
      do_reset();
      request(4'h9);
      chk("acc_busy", 32'(req_ready), 32'd0);
      tick(); tick(); tick();
      chk("acc_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("acc_valid", 32'(rsp_valid), 32'd1);
      chk("acc_data", 32'(rsp_data), 32'h8);
      chk("acc_fb", 32'(rsp_fallback), 32'd0);
      chk("acc_rand", 32'(rand_out), 32'h1);
      req_valid = 1'b1;
      req_lim   = 4'h0;
      tick();
      req_valid = 1'b0;
      tick();
      chk("acc_hold_valid", 32'(rsp_valid), 32'd1);
      chk("acc_hold_data", 32'(rsp_data), 32'h8);
      handshake();
      chk("acc_done_valid", 32'(rsp_valid), 32'd0);
      chk("acc_done_ready", 32'(req_ready), 32'd1);
      tick();
      chk("acc_no_queue", 32'(rsp_valid), 32'd0);

      // fallback, lim=5: 8-5=3
      do_reset();
      request(4'h5);
      tick(); tick(); tick(); tick();
      chk("fb5_valid", 32'(rsp_valid), 32'd1);
      chk("fb5_data", 32'(rsp_data), 32'h3);
      chk("fb5_fb", 32'(rsp_fallback), 32'd1);

      // reset while in HOLD with a request pending
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_lim   = 4'h3;
      tick();
      chk("rsth_valid", 32'(rsp_valid), 32'd0);
      chk("rsth_ready", 32'(req_ready), 32'd1);
      chk("rsth_rand", 32'(rand_out), 32'hF);
      rst_n     = 1'b1;
      req_valid = 1'b0;
      tick(); tick();
      chk("rsth_noresp", 32'(rsp_valid), 32'd0);
      chk("rsth_idle", 32'(req_ready), 32'd1);

      // fallback, lim=2: 8-2=6 not below 2, so lim-1
      request(4'h2);
      tick(); tick(); tick(); tick();
      chk("fb2_valid", 32'(rsp_valid), 32'd1);
      chk("fb2_data", 32'(rsp_data), 32'h1);
      chk("fb2_fb", 32'(rsp_fallback), 32'd1);
      handshake();

      // zero limit: immediate response, LFSR untouched (state is 1)
      request(4'h0);
      chk("zero_valid", 32'(rsp_valid), 32'd1);
      chk("zero_data", 32'(rsp_data), 32'h0);
      chk("zero_fb", 32'(rsp_fallback), 32'd0);
      chk("zero_rand", 32'(rand_out), 32'h1);
      handshake();

      // seed loading
      seed_load = 1'b1;
      seed_in   = 4'h0;
      tick();
      chk("seed_zero", 32'(rand_out), 32'hF);
      seed_in = 4'h3;
      tick();
      seed_load = 1'b0;
      chk("seed_three", 32'(rand_out), 32'h3);

      // seed load during DRAW: F rejected, then candidate 9 accepted for lim=A
      do_reset();
      request(4'hA);
      seed_load = 1'b1;
      seed_in   = 4'h9;
      tick();
      seed_load = 1'b0;
      chk("sdraw_pending", 32'(rsp_valid), 32'd0);
      chk("sdraw_rand", 32'(rand_out), 32'h9);
      tick();
      chk("sdraw_valid", 32'(rsp_valid), 32'd1);
      chk("sdraw_data", 32'(rsp_data), 32'h9);
      chk("sdraw_fb", 32'(rsp_fallback), 32'd0);
      chk("sdraw_step", 32'(rand_out), 32'h3);

      // reset while in DRAW
      do_reset();
      request(4'h1);
      tick();
      rst_n = 1'b0;
      tick();
      chk("rstd_valid", 32'(rsp_valid), 32'd0);
      chk("rstd_ready", 32'(req_ready), 32'd1);
      chk("rstd_rand", 32'(rand_out), 32'hF);
      rst_n = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("rstd_noresp", 32'(rsp_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
